voice_allocator: RTL
====================

# voice_allocator

Assigns incoming key press/release events to a fixed pool of note slots. It maintains the slot table that drives the per-voice note inputs of the note-to-frequency lookup and the tone generators behind it. The block sits between the keyboard/MIDI event decoder and the frequency lookup. A voice-stealing policy is applied when all slots are busy.

## Interface
- NUM_VOICES, 16: number of note slots; must match the frequency lookup's slot count.
- AGE_W, 8: width of each slot's saturating age counter.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept an event this cycle
- ev_on  in  1  1 = key press, 0 = key release
- ev_note  in  8  note code: [7] reserved (must be 0), [6:4] zone, [3:0] semitone 1..12
- all_off  in  1  synchronous panic: silence every slot
- notes  out  8 x NUM_VOICES  per-slot note code; 8'h00 = silent slot
- active_mask  out  NUM_VOICES  bit i = 1 when notes[i] != 0
- voice_count  out  $clog2(NUM_VOICES)+1  number of active slots
- overflow  out  1  one-cycle pulse when a note-on could not get a free slot

## Operation
- Valid note: bit7 = 0, zone 2..7, semitone 1..12. Anything else is accepted and discarded with no table change and no overflow.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE → SCAN on ev_valid && ev_ready; ev_on and ev_note are registered.
  - SCAN → COMMIT unconditionally. In SCAN the block registers:
    - the match slot: lowest index whose notes == the registered note;
    - the free slot: lowest index with notes == 0;
    - the oldest active slot: largest age, ties to lowest index.
  - COMMIT → IDLE. The table is updated on this edge.
- ev_ready = (state == IDLE) && !all_off && !rst.
- Note-on rules:
  - Match exists: retrigger. That slot's age is cleared to 0; no new slot is allocated.
  - Otherwise, free slot exists: write the note into it and set its age to 0.
  - Otherwise (full): behaviour depends on the configuration (see Configuration).
- On every committed note-on, all other active slots' ages increment, saturating at 2^AGE_W-1.
- Note-off: the matching slot is written to 8'h00 and its age to 0. If there is no match, the event is ignored.
- all_off: takes effect from any state. On the next edge all notes and ages are 0, the FSM goes to IDLE, any in-flight event is discarded, and overflow is 0.
- active_mask and voice_count are registered alongside the table and are always consistent with notes.
- The same note never occupies two slots.

## Timing
- An event is accepted at edge N and the table update is visible after edge N+2. ev_ready is high again in the cycle after edge N+2. Maximum throughput is one event per 3 cycles.
- overflow is registered. It is high for exactly the one cycle in which the COMMIT result is visible.
- Reset values:
  - notes all 8'h00, ages 0, active_mask 0, voice_count 0;
  - overflow 0, state IDLE, ev_ready 1 (after rst deasserts).
- rst mid-operation behaves like all_off and also clears the registered event.
- Priority: rst > all_off > FSM.
- notes is register-driven with no combinational path from ev_* inputs, so the downstream frequency lookup sees stable values for whole cycles.

## Configuration
- VOICE_STEAL_EN defined: a note-on with no match and no free slot overwrites the oldest active slot and resets that slot's age to 0. overflow also pulses to flag the steal.
- VOICE_STEAL_EN undefined: the same case leaves the table unchanged, the note is dropped, and overflow pulses.
- In both cases ages are updated only when a slot is written.

## Test plan
- Reset, then note-on 8'h4a → after 3 cycles notes[0] = 8'h4a, active_mask = 16'h0001, voice_count = 1, overflow = 0.
- Note-on 8'h41, 8'h45, 8'h48 in sequence, then note-off 8'h45 → notes[0..2] = 41, 00, 48 and voice_count = 2. A following note-on 8'h4c lands in slot 1.
- Fill all 16 slots with 8'h21..8'h2c and 8'h31..8'h34 in that order, then note-on 8'h5a:
  - with VOICE_STEAL_EN: notes[0] = 8'h5a, overflow pulses once, voice_count stays 16;
  - without: table unchanged, overflow pulses once.
- Note-on 8'h43 twice, then invalid codes 8'h4d, 8'h10 and 8'hc3 → only one slot holds 8'h43. Invalid codes cause no change, no overflow, and ev_ready returns after 3 cycles each.
- Hold ev_valid with 5 queued note-ons and assert all_off while the FSM is in SCAN → next cycle notes all 0, voice_count 0, state IDLE. The in-flight event is lost and the next event is accepted normally.
- Assert rst mid-COMMIT → all outputs at reset values on the next cycle. Check ev_ready deasserts while rst is high.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: maps key press/release events onto NUM_VOICES note slots.
// Define VOICE_STEAL_EN to overwrite the oldest slot when a note-on finds the table full.
module voice_allocator #(
  parameter int NUM_VOICES = 16,
  parameter int AGE_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ev_valid,
  output logic ev_ready,
  input  logic ev_on,
  input  logic [7:0] ev_note,
  input  logic all_off,
  output logic [8*NUM_VOICES-1:0] notes,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic [$clog2(NUM_VOICES):0] voice_count,
  output logic overflow
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = IW + 1;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  logic [1:0] state_q, state_d;
  logic on_q;
  logic [7:0] note_q;
  logic [7:0] notes_q [NUM_VOICES];
  logic [7:0] notes_d [NUM_VOICES];
  logic [AGE_W-1:0] age_q [NUM_VOICES];
  logic [AGE_W-1:0] age_d [NUM_VOICES];
  logic match_hit, free_hit, old_hit, match_hit_q, free_hit_q;
  logic [IW-1:0] match_idx, free_idx, old_idx, match_idx_q, free_idx_q, old_idx_q, tgt;
  logic [AGE_W-1:0] old_age;
  logic [NUM_VOICES-1:0] mask_q, mask_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d, wr, valid;
  logic [7:0] wnote;
  assign ev_ready = (state_q == IDLE) && !all_off && !rst;
  assign valid = !note_q[7] && note_q[6:4] >= 3'd2 && note_q[3:0] >= 4'd1 && note_q[3:0] <= 4'd12;
  assign active_mask = mask_q;
  assign voice_count = count_q;
  assign overflow = overflow_q;
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign notes[8*v +: 8] = notes_q[v];
  end
  always_comb begin
    state_d = state_q == IDLE ? ((ev_valid && ev_ready) ? SCAN : IDLE) :
              state_q == SCAN ? COMMIT : IDLE;
  end
  // Lowest-index search for match/free; oldest uses strict > so ties keep the lower slot.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit = 1'b0;
    free_idx = '0;
    old_hit = 1'b0;
    old_idx = '0;
    old_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && notes_q[i] == note_q) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!free_hit && notes_q[i] == 8'h00) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
      if (notes_q[i] != 8'h00 && (!old_hit || age_q[i] > old_age)) begin
        old_hit = 1'b1;
        old_idx = IW'(i);
        old_age = age_q[i];
      end
    end
  end
  always_comb begin
    notes_d = notes_q;
    age_d = age_q;
    overflow_d = 1'b0;
    wr = 1'b0;
    wnote = 8'h00;
    tgt = match_hit_q ? match_idx_q : free_hit_q ? free_idx_q : old_idx_q;
    if (state_q == COMMIT && valid) begin
      wr = on_q ? (match_hit_q || free_hit_q || STEAL) : match_hit_q;
      overflow_d = on_q && !match_hit_q && !free_hit_q;
      wnote = on_q ? note_q : 8'h00;
    end
    if (wr) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (on_q && IW'(i) != tgt && notes_q[i] != 8'h00 && age_q[i] != '1)
          age_d[i] = age_q[i] + 1'b1;
      notes_d[tgt] = wnote;
      age_d[tgt] = '0;
    end
    mask_d = '0;
    count_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mask_d[i] = notes_d[i] != 8'h00;
      count_d = count_d + CW'(mask_d[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || all_off) begin
      state_q <= IDLE;
      on_q <= 1'b0;
      note_q <= 8'h00;
      notes_q <= '{default: '0};
      age_q <= '{default: '0};
      match_hit_q <= 1'b0;
      free_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_idx_q <= '0;
      old_idx_q <= '0;
      mask_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ev_valid) begin
        on_q <= ev_on;
        note_q <= ev_note;
      end
      if (state_q == SCAN) begin
        match_hit_q <= match_hit;
        free_hit_q <= free_hit;
        match_idx_q <= match_idx;
        free_idx_q <= free_idx;
        old_idx_q <= old_idx;
      end
      notes_q <= notes_d;
      age_q <= age_d;
      mask_q <= mask_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
